// File: rtl/secret_feeder_pkg.sv
// ---------------------------------------------------------------------------
// secret_feeder_pkg
// Shared types for the secret operand feeder:
//   OPERAND_W       width of one operand and of the returned result
//   state_t         issue state (IDLE / ISSUE / PAUSED)
//   operand_pair_t  one {a, b} pair as it sits in the operand FIFO
// ---------------------------------------------------------------------------
package secret_feeder_pkg;

  localparam int OPERAND_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    PAUSED = 2'd2
  } state_t;

  typedef struct packed {
    logic [OPERAND_W-1:0] a;
    logic [OPERAND_W-1:0] b;
  } operand_pair_t;

endpackage

// File: rtl/secret_feeder_fifo.sv
// ---------------------------------------------------------------------------
// secret_feeder_fifo
// Synchronous FIFO of operand pairs with a show-ahead head. It has no bypass,
// so a pair written on an edge is first visible at rdata after that edge.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, wdata  write one pair (ignored while full)
//   pop          drop the head pair (ignored while empty)
//   rdata        current head pair (valid while !empty)
//   full, empty  occupancy flags
// ---------------------------------------------------------------------------
module secret_feeder_fifo
  import secret_feeder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  operand_pair_t wdata,
  input  logic          pop,
  output operand_pair_t rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  // The extra MSB on each pointer distinguishes full from empty when the
  // index bits are equal.
  typedef logic [AW:0] ptr_t;

  ptr_t          wr_ptr;
  ptr_t          rd_ptr;
  operand_pair_t mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ptr_t'(1);
    end
  end

  // NOTE: the storage array is deliberately left out of reset; the pointers
  // alone define which entries are valid, so clearing the data buys nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/secret_operand_feeder.sv
// ---------------------------------------------------------------------------
// secret_operand_feeder
// Front end for the secret accumulator block. Operand pairs arrive over a
// valid/ready handshake, are buffered in a small FIFO and issued one per
// cycle on a/b (zeros when idle, so the accumulator is left untouched). The
// block's result x is captured two cycles after issue and tagged res_valid.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       operand handshake (in_ready = !full)
//   in_a, in_b              incoming operand pair
//   pause                   hold issue while high (FIFO frozen)
//   a, b                    registered operands to the secret block
//   x                       result from the secret block
//   res_valid, res_data     one beat per issued pair, data = captured x
//   issued_count            pairs issued since reset (wraps)
//   busy                    FIFO non-empty or results still in flight
//
// Build option SECRET_FEEDER_SHADOW_EN adds:
//   shadow_accum            running sum of issued a values
//   shadow_gt10             shadow_accum > 10 (block will return b only)
// ---------------------------------------------------------------------------
module secret_operand_feeder
  import secret_feeder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = OPERAND_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             pause,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] x,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic [31:0]      issued_count,
  output logic             busy
`ifdef SECRET_FEEDER_SHADOW_EN
  ,
  output logic [WIDTH-1:0] shadow_accum,
  output logic             shadow_gt10
`endif
);

  state_t        state;
  state_t        next_state;
  operand_pair_t head;
  operand_pair_t wr_pair;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          issue_d0;
  logic          issue_d1;

  assign wr_pair = '{a: in_a, b: in_b};

  secret_feeder_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr_pair),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // State register: ISSUE means a/b carry a popped pair this cycle, so the
  // state itself serves as the first stage of the result tag pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every combinational output gets a default on entry so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = IDLE;
    if (pause) begin
      next_state = empty ? IDLE : PAUSED;
    end else if (!empty) begin
      next_state = ISSUE;
    end
  end

  // in_ready comes from the pre-edge full flag, so a push coinciding with a
  // pop on a full FIFO is refused for that cycle.
  always_comb begin
    pop      = (next_state == ISSUE);
    push     = in_valid && !full;
    in_ready = !full;
    issue_d0 = (state == ISSUE);
    busy     = !empty || issue_d0 || issue_d1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a            <= '0;
      b            <= '0;
      issued_count <= '0;
      issue_d1     <= 1'b0;
      res_valid    <= 1'b0;
      res_data     <= '0;
    end else begin
      if (pop) begin
        a            <= head.a;
        b            <= head.b;
        issued_count <= issued_count + 32'd1;
      end else begin
        // Zero operands leave the downstream accumulator unchanged.
        a <= '0;
        b <= '0;
      end
      // x reflects the pair one edge after issue; capture it one edge later.
      issue_d1  <= issue_d0;
      res_valid <= issue_d1;
      if (issue_d1) res_data <= x;
    end
  end

`ifdef SECRET_FEEDER_SHADOW_EN
  // Mirrors the downstream accumulator: it adds a on the same edge that the
  // pair is issued, which is when a lands on the block's input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_accum <= '0;
    end else if (pop) begin
      shadow_accum <= shadow_accum + head.a;
    end
  end

  assign shadow_gt10 = (shadow_accum > WIDTH'(10));
`endif

endmodule

// File: tb/tb_secret_operand_feeder.sv
// ---------------------------------------------------------------------------
// tb_secret_operand_feeder
// Drives the feeder with directed operand sequences, models the secret
// accumulator downstream, and compares every cycle against a queue-based
// model. Hand-computed literals pin the model on key results.
// ---------------------------------------------------------------------------
module tb_secret_operand_feeder;

  localparam int DEPTH = 4;
  localparam int W     = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         pause;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] x;
  logic         res_valid;
  logic [W-1:0] res_data;
  logic [31:0]  issued_count;
  logic         busy;
`ifdef SECRET_FEEDER_SHADOW_EN
  logic [W-1:0] shadow_accum;
  logic         shadow_gt10;
`endif

  secret_operand_feeder #(
    .DEPTH (DEPTH),
    .WIDTH (W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .pause        (pause),
    .a            (a),
    .b            (b),
    .x            (x),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .issued_count (issued_count),
    .busy         (busy)
`ifdef SECRET_FEEDER_SHADOW_EN
    ,
    .shadow_accum (shadow_accum),
    .shadow_gt10  (shadow_gt10)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream secret block: accumulates a; returns b once the sum exceeds
  // 10, otherwise a+b+9. Result registered one cycle.
  logic [W-1:0] sec_acc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_acc <= '0;
      x       <= '0;
    end else begin
      sec_acc <= sec_acc + a;
      x       <= ((sec_acc + a) > 32'd10) ? b : (a + b + 32'd9);
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] q_a[$];
  logic [W-1:0] q_b[$];
  int           due_q[$];
  logic [W-1:0] dat_q[$];
  int           cyc = 0;
  logic [W-1:0] exp_a, exp_b, exp_res_data, m_acc;
  logic [31:0]  m_issued;
  logic         exp_res_valid;
  bit           full_pre;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a.delete(); q_b.delete(); due_q.delete(); dat_q.delete();
      exp_a = '0; exp_b = '0; exp_res_data = '0; exp_res_valid = 1'b0;
      m_acc = '0; m_issued = '0;
    end else begin
      cyc++;
      full_pre = (q_a.size() == DEPTH);
      exp_a = '0;
      exp_b = '0;
      if (!pause && q_a.size() > 0) begin
        exp_a = q_a.pop_front();
        exp_b = q_b.pop_front();
        m_issued++;
        m_acc += exp_a;
        due_q.push_back(cyc + 2);
        dat_q.push_back((m_acc > 32'd10) ? exp_b : (exp_a + exp_b + 32'd9));
      end
      if (in_valid && !full_pre) begin
        q_a.push_back(in_a);
        q_b.push_back(in_b);
      end
      exp_res_valid = 1'b0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        exp_res_valid = 1'b1;
        exp_res_data  = dat_q[0];
        void'(due_q.pop_front());
        void'(dat_q.pop_front());
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit           chk_en = 1'b0;
  logic [W-1:0] res_log[$];
  int           res_cyc[$];

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("a", a, exp_a);
      check("b", b, exp_b);
      check("res_valid", 32'(res_valid), 32'(exp_res_valid));
      check("res_data", res_data, exp_res_data);
      check("issued_count", issued_count, m_issued);
      check("in_ready", 32'(in_ready), 32'(q_a.size() < DEPTH));
      check("busy", 32'(busy), 32'(q_a.size() > 0 || due_q.size() > 0));
`ifdef SECRET_FEEDER_SHADOW_EN
      check("shadow_accum", shadow_accum, m_acc);
      check("shadow_gt10", 32'(shadow_gt10), 32'(m_acc > 32'd10));
`endif
      if (res_valid) begin
        res_log.push_back(res_data);
        res_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Offers one pair, waits (bounded) for acceptance, returns one cycle later.
  task automatic push(input logic [W-1:0] pa, input logic [W-1:0] pb);
    int n = 0;
    in_valid = 1'b1;
    in_a     = pa;
    in_b     = pb;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    check("push_accept", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    check("drain", 32'(busy), 32'd0);
    repeat (2) step();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_a"}, a, 32'd0);
    check({tag, "_b"}, b, 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_data"}, res_data, 32'd0);
    check({tag, "_issued"}, issued_count, 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; pause = 1'b0;
    #3;
    check_reset_values("por");
    @(negedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    step();

    // Single pair: 1+2+9 = 12 two cycles after issue.
    base = res_log.size();
    push(32'd1, 32'd2);
    drain();
    check("t1_nres", 32'(res_log.size() - base), 32'd1);
    if (res_log.size() > base) check("t1_res", res_log[base], 32'd12);
    check("t1_issued", issued_count, 32'd1);

    // Back-to-back: acc 4,9,16 -> 16, 20, then b=8.
    base = res_log.size();
    push(32'd3, 32'd4);
    push(32'd5, 32'd6);
    push(32'd7, 32'd8);
    drain();
    check("t2_nres", 32'(res_log.size() - base), 32'd3);
    if (res_log.size() >= base + 3) begin
      check("t2_res0", res_log[base],     32'd16);
      check("t2_res1", res_log[base + 1], 32'd20);
      check("t2_res2", res_log[base + 2], 32'd8);
      check("t2_gap0", 32'(res_cyc[base + 1] - res_cyc[base]), 32'd1);
      check("t2_gap1", 32'(res_cyc[base + 2] - res_cyc[base + 1]), 32'd1);
    end
    check("t2_issued", issued_count, 32'd4);

    // Fill while paused: fifth beat held until a slot frees.
    base = res_log.size();
    pause = 1'b1;
    fork
      begin
        for (int i = 0; i < 5; i++) push(32'(10 * (i + 1)), 32'(i + 1));
      end
      begin
        repeat (8) @(negedge clk);
        #2;
        check("t3_full_ready", 32'(in_ready), 32'd0);
        check("t3_a_paused", a, 32'd0);
        check("t3_issued_frozen", issued_count, 32'd4);
        pause = 1'b0;
      end
    join
    drain();
    check("t3_nres", 32'(res_log.size() - base), 32'd5);
    if (res_log.size() >= base + 5) begin
      for (int i = 0; i < 5; i++) check("t3_res", res_log[base + i], 32'(i + 1));
      check("t3_span", 32'(res_cyc[base + 4] - res_cyc[base]), 32'd4);
    end
    check("t3_issued", issued_count, 32'd9);

    // Pause between two issues: first result still lands on schedule.
    base = res_log.size();
    push(32'd2, 32'd3);
    push(32'd4, 32'd5);
    pause = 1'b1;
    repeat (3) step();
    check("t4_a_zero", a, 32'd0);
    check("t4_b_zero", b, 32'd0);
    check("t4_busy", 32'(busy), 32'd1);
    check("t4_inflight_res", 32'(res_log.size() - base), 32'd1);
    pause = 1'b0;
    drain();
    check("t4_nres", 32'(res_log.size() - base), 32'd2);
    if (res_log.size() >= base + 2) begin
      check("t4_res0", res_log[base],     32'd3);
      check("t4_res1", res_log[base + 1], 32'd5);
    end

    // Reset with two queued and one in flight.
    push(32'd1, 32'd1);
    push(32'd2, 32'd2);
    pause = 1'b1;
    push(32'd3, 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    base = res_log.size();
    @(negedge clk); #1;
    rst_n = 1'b1;
    pause = 1'b0;
    repeat (6) step();
    check("t5_no_res", 32'(res_log.size() - base), 32'd0);
    check("t5_issued", issued_count, 32'd0);

    // a=6 twice from a fresh accumulator: 6+1+9=16, then sum 12 returns b=2.
    base = res_log.size();
    push(32'd6, 32'd1);
`ifdef SECRET_FEEDER_SHADOW_EN
    step();
    check("t6_shadow0", shadow_accum, 32'd6);
    check("t6_gt10_0", 32'(shadow_gt10), 32'd0);
`endif
    push(32'd6, 32'd2);
`ifdef SECRET_FEEDER_SHADOW_EN
    step();
    check("t6_shadow1", shadow_accum, 32'd12);
    check("t6_gt10_1", 32'(shadow_gt10), 32'd1);
`endif
    drain();
    check("t6_nres", 32'(res_log.size() - base), 32'd2);
    if (res_log.size() >= base + 2) begin
      check("t6_res0", res_log[base],     32'd16);
      check("t6_res1", res_log[base + 1], 32'd2);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
